// File: rtl/sc_mem_access_ctrl.sv
// Data-memory access sequencer: turns MIR RD/WR into a req/ack memory transaction,
// stalls the microsequencer until it completes, and flags illegal or timed-out accesses.
module sc_mem_access_ctrl #(
  parameter int unsigned DATAWIDTH_ADDR    = 32,
  parameter int unsigned DATAWIDTH_DATA    = 32,
  parameter int unsigned TIMEOUT_CYCLES    = 15,
  parameter int unsigned DATAWIDTH_TIMEOUT = 4
) (
  input  logic                      SC_MemCtrl_CLOCK_50,
  input  logic                      SC_MemCtrl_RESET_InHigh,
  input  logic                      SC_MemCtrl_Read_In,
  input  logic                      SC_MemCtrl_Write_In,
  input  logic [DATAWIDTH_ADDR-1:0] SC_MemCtrl_Addr_InBUS,
  input  logic [DATAWIDTH_DATA-1:0] SC_MemCtrl_WrData_InBUS,
  input  logic                      SC_MemCtrl_ErrorClear_In,
  input  logic                      SC_MemCtrl_Mem_Ack_In,
  input  logic [DATAWIDTH_DATA-1:0] SC_MemCtrl_Mem_RdData_InBUS,
  output logic                      SC_MemCtrl_Mem_Req_Out,
  output logic                      SC_MemCtrl_Mem_We_Out,
  output logic [DATAWIDTH_ADDR-1:0] SC_MemCtrl_Mem_Addr_OutBUS,
  output logic [DATAWIDTH_DATA-1:0] SC_MemCtrl_Mem_WrData_OutBUS,
  output logic [DATAWIDTH_DATA-1:0] SC_MemCtrl_RdData_OutBUS,
  output logic                      SC_MemCtrl_Stall_Out,
  output logic                      SC_MemCtrl_Error_Out
);

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDone
  } stateT;

  // Last wait-count value at which a missing Ack becomes a timeout.
  localparam logic [DATAWIDTH_TIMEOUT-1:0] WaitLast = DATAWIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);
  localparam logic [DATAWIDTH_TIMEOUT-1:0] WaitOne  = DATAWIDTH_TIMEOUT'(1);

  stateT                      stateQ, stateD;
  logic                       reqQ, reqD;
  logic                       weQ, weD;
  logic                       errQ, errD;
  logic [DATAWIDTH_TIMEOUT-1:0] waitQ, waitD;
  logic [DATAWIDTH_ADDR-1:0]  addrQ, addrD;
  logic [DATAWIDTH_DATA-1:0]  wrDataQ, wrDataD;
  logic [DATAWIDTH_DATA-1:0]  rdDataQ, rdDataD;
  logic                       stall;
  logic                       errSet;
  logic                       oneOp;
  logic                       bothOp;

  assign oneOp  = SC_MemCtrl_Read_In ^ SC_MemCtrl_Write_In;
  assign bothOp = SC_MemCtrl_Read_In & SC_MemCtrl_Write_In;

  always_comb begin
    stateD  = stateQ;
    weD     = weQ;
    waitD   = waitQ;
    addrD   = addrQ;
    wrDataD = wrDataQ;
    rdDataD = rdDataQ;
    errSet  = 1'b0;
    stall   = 1'b0;

    unique case (stateQ)
      StIdle: begin
        if (bothOp) begin
          errSet = 1'b1;
        end else if (oneOp) begin
          addrD   = SC_MemCtrl_Addr_InBUS;
          wrDataD = SC_MemCtrl_WrData_InBUS;
          weD     = SC_MemCtrl_Write_In;
          waitD   = '0;
          stall   = 1'b1;
          stateD  = StReq;
        end
      end
      StReq: begin
        stall = 1'b1;
        // Ack on the last allowed cycle is checked first so it beats the timeout.
        if (SC_MemCtrl_Mem_Ack_In) begin
          if (!weQ) begin
            rdDataD = SC_MemCtrl_Mem_RdData_InBUS;
          end
          stateD = StDone;
        end else if (waitQ == WaitLast) begin
          errSet = 1'b1;
          stateD = StDone;
        end else begin
          waitD = waitQ + WaitOne;
        end
      end
      StDone: begin
        // RD/WR still belong to the finished microinstruction here.
        stateD = StIdle;
      end
      default: begin
        stateD = StIdle;
      end
    endcase

    reqD = (stateD == StReq);

    if (errSet) begin
      errD = 1'b1;
    end else if (SC_MemCtrl_ErrorClear_In) begin
      errD = 1'b0;
    end else begin
      errD = errQ;
    end
  end

  always_ff @(posedge SC_MemCtrl_CLOCK_50 or posedge SC_MemCtrl_RESET_InHigh) begin
    if (SC_MemCtrl_RESET_InHigh) begin
      stateQ  <= StIdle;
      reqQ    <= 1'b0;
      weQ     <= 1'b0;
      errQ    <= 1'b0;
      waitQ   <= '0;
      addrQ   <= '0;
      wrDataQ <= '0;
      rdDataQ <= '0;
    end else begin
      stateQ  <= stateD;
      reqQ    <= reqD;
      weQ     <= weD;
      errQ    <= errD;
      waitQ   <= waitD;
      addrQ   <= addrD;
      wrDataQ <= wrDataD;
      rdDataQ <= rdDataD;
    end
  end

  assign SC_MemCtrl_Mem_Req_Out       = reqQ;
  assign SC_MemCtrl_Mem_We_Out        = weQ;
  assign SC_MemCtrl_Mem_Addr_OutBUS   = addrQ;
  assign SC_MemCtrl_Mem_WrData_OutBUS = wrDataQ;
  assign SC_MemCtrl_RdData_OutBUS     = rdDataQ;
  assign SC_MemCtrl_Stall_Out         = stall;
  assign SC_MemCtrl_Error_Out         = errQ;

endmodule

// File: tb/tb_sc_mem_access_ctrl.sv
// Bench for sc_mem_access_ctrl: directed scenarios plus random traffic, all checked every
// cycle against a transaction-level model of the access protocol.
module tb_sc_mem_access_ctrl;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd = 1'b0, wr = 1'b0, ack = 1'b0, clr = 1'b0;
  logic [31:0] addr = '0, wdata = '0, memData = '0;
  logic        req, we, stall, err;
  logic [31:0] memAddr, memWr, rdData;

  sc_mem_access_ctrl dut (
    .SC_MemCtrl_CLOCK_50         (clk),
    .SC_MemCtrl_RESET_InHigh     (rst),
    .SC_MemCtrl_Read_In          (rd),
    .SC_MemCtrl_Write_In         (wr),
    .SC_MemCtrl_Addr_InBUS       (addr),
    .SC_MemCtrl_WrData_InBUS     (wdata),
    .SC_MemCtrl_ErrorClear_In    (clr),
    .SC_MemCtrl_Mem_Ack_In       (ack),
    .SC_MemCtrl_Mem_RdData_InBUS (memData),
    .SC_MemCtrl_Mem_Req_Out      (req),
    .SC_MemCtrl_Mem_We_Out       (we),
    .SC_MemCtrl_Mem_Addr_OutBUS  (memAddr),
    .SC_MemCtrl_Mem_WrData_OutBUS(memWr),
    .SC_MemCtrl_RdData_OutBUS    (rdData),
    .SC_MemCtrl_Stall_Out        (stall),
    .SC_MemCtrl_Error_Out        (err)
  );

  always #5 clk = ~clk;

  // Model: an access is "in flight" for some number of memory cycles, followed by one
  // completion cycle in which the sequencer is released.
  bit          mInFlight, mCompleting, mWe, mErr;
  int          mCyclesWaited;
  logic [31:0] mAddr, mWd, mRd;

  int vectors = 0, miscompares = 0;
  int reqCnt, stallCnt, pulses;
  bit prevReq;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  task automatic modelReset();
    mInFlight = 0; mCompleting = 0; mWe = 0; mErr = 0; mCyclesWaited = 0;
    mAddr = '0; mWd = '0; mRd = '0;
  endtask

  task automatic clearCounts();
    reqCnt = 0; stallCnt = 0; pulses = 0; prevReq = 0;
  endtask

  // One clock cycle: drive at negedge, compare, then advance the model at posedge.
  task automatic step(input bit r, input bit w, input bit a, input bit c,
                      input logic [31:0] ad, input logic [31:0] wd, input logic [31:0] md);
    bit expStall, raiseErr;
    @(negedge clk);
    rd = r; wr = w; ack = a; clr = c; addr = ad; wdata = wd; memData = md;
    #1;
    expStall = mInFlight || (!mCompleting && (r != w));
    chk("req", {31'b0, req}, {31'b0, mInFlight});
    chk("stall", {31'b0, stall}, {31'b0, expStall});
    chk("error", {31'b0, err}, {31'b0, mErr});
    chk("rdData", rdData, mRd);
    chk("memAddr", memAddr, mAddr);
    chk("memWrData", memWr, mWd);
    chk("we", {31'b0, we}, {31'b0, mWe});
    reqCnt += int'(req);
    stallCnt += int'(stall);
    if (req && !prevReq) pulses++;
    prevReq = req;
    @(posedge clk);
    raiseErr = 0;
    if (mCompleting) begin
      mCompleting = 0;
    end else if (mInFlight) begin
      mCyclesWaited++;
      if (a) begin
        if (!mWe) mRd = md;
        mInFlight = 0; mCompleting = 1;
      end else if (mCyclesWaited == TO) begin
        raiseErr = 1;
        mInFlight = 0; mCompleting = 1;
      end
    end else if (r && w) begin
      raiseErr = 1;
    end else if (r || w) begin
      mAddr = ad; mWd = wd; mWe = w; mInFlight = 1; mCyclesWaited = 0;
    end
    if (raiseErr) mErr = 1;
    else if (c) mErr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, '0);
  endtask

  initial begin
    int ackMode;
    modelReset();
    clearCounts();
    #2;
    chk("resetReq", {31'b0, req}, 32'd0);
    chk("resetErr", {31'b0, err}, 32'd0);
    chk("resetRdData", rdData, 32'd0);
    @(negedge clk); rst = 1'b0;
    idle(2);

    // Read with Ack on the third REQ cycle; RD held through REQ and DONE.
    clearCounts();
    step(1, 0, 0, 0, 32'h40, 32'h0, 32'h0);
    step(1, 0, 0, 0, 32'h40, 32'h0, 32'h0);
    step(1, 0, 0, 0, 32'h40, 32'h0, 32'h0);
    step(1, 0, 1, 0, 32'h40, 32'h0, 32'hDEADBEEF);
    step(1, 0, 0, 0, 32'h40, 32'h0, 32'h0);
    #1;
    chk("t2ReqCycles", reqCnt, 32'd3);
    chk("t2StallCycles", stallCnt, 32'd4);
    chk("t2RdData", rdData, 32'hDEADBEEF);
    chk("t2Error", {31'b0, err}, 32'd0);
    chk("t2Addr", memAddr, 32'h40);

    // Write with same-cycle Ack.
    clearCounts();
    step(0, 1, 0, 0, 32'h80, 32'h12345678, 32'h0);
    step(0, 1, 1, 0, 32'h80, 32'h12345678, 32'hAAAA5555);
    step(0, 1, 0, 0, 32'h80, 32'h12345678, 32'h0);
    #1;
    chk("t3ReqCycles", reqCnt, 32'd1);
    chk("t3StallCycles", stallCnt, 32'd2);
    chk("t3We", {31'b0, we}, 32'd1);
    chk("t3MemWrData", memWr, 32'h12345678);
    chk("t3RdDataKept", rdData, 32'hDEADBEEF);

    // Read that times out.
    clearCounts();
    step(1, 0, 0, 0, 32'h100, 32'h0, 32'h0);
    for (int i = 0; i < TO; i++) step(1, 0, 0, 0, 32'h100, 32'h0, 32'h11111111);
    step(1, 0, 0, 0, 32'h100, 32'h0, 32'h0);
    #1;
    chk("t4TimeoutReqCycles", reqCnt, 32'd15);
    chk("t4TimeoutError", {31'b0, err}, 32'd1);
    chk("t4TimeoutRdKept", rdData, 32'hDEADBEEF);
    step(0, 0, 0, 1, '0, '0, '0);
    #1;
    chk("t5ClearError", {31'b0, err}, 32'd0);

    // Read with Ack on the final allowed cycle.
    clearCounts();
    step(1, 0, 0, 0, 32'h104, 32'h0, 32'h0);
    for (int i = 0; i < TO - 1; i++) step(1, 0, 0, 0, 32'h104, 32'h0, 32'h0);
    step(1, 0, 1, 0, 32'h104, 32'h0, 32'hCAFEF00D);
    step(1, 0, 0, 0, 32'h104, 32'h0, 32'h0);
    #1;
    chk("t4LastAckReqCycles", reqCnt, 32'd15);
    chk("t4LastAckError", {31'b0, err}, 32'd0);
    chk("t4LastAckRdData", rdData, 32'hCAFEF00D);

    // Reset in the middle of a pending read.
    step(1, 0, 0, 0, 32'h200, 32'h0, 32'h0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 32'h200, 32'h0, 32'h0);
    @(negedge clk);
    rd = 0; rst = 1'b1;
    #1;
    chk("t1ResetReq", {31'b0, req}, 32'd0);
    chk("t1ResetStall", {31'b0, stall}, 32'd0);
    chk("t1ResetErr", {31'b0, err}, 32'd0);
    chk("t1ResetRdData", rdData, 32'd0);
    modelReset();
    @(negedge clk); rst = 1'b0;
    idle(1);

    // Illegal RD+WR, then clear coincident with a timeout.
    clearCounts();
    step(1, 1, 0, 0, 32'h300, 32'h5, 32'h0);
    #1;
    chk("t5IllegalErr", {31'b0, err}, 32'd1);
    chk("t5IllegalNoReq", reqCnt, 32'd0);
    chk("t5IllegalNoStall", stallCnt, 32'd0);
    step(0, 0, 0, 1, '0, '0, '0);
    step(1, 0, 0, 0, 32'h304, 32'h0, 32'h0);
    for (int i = 0; i < TO - 1; i++) step(1, 0, 0, 0, 32'h304, 32'h0, 32'h0);
    step(1, 0, 0, 1, 32'h304, 32'h0, 32'h0);
    #1;
    chk("t5SetBeatsClear", {31'b0, err}, 32'd1);
    step(0, 0, 0, 1, '0, '0, '0);

    // Back-to-back read then write with spurious Acks in IDLE and DONE.
    clearCounts();
    step(0, 0, 1, 0, 32'h0, 32'h0, 32'h99);
    step(1, 0, 1, 0, 32'h400, 32'h0, 32'h77);
    step(1, 0, 1, 0, 32'h400, 32'h0, 32'h600D600D);
    step(0, 1, 1, 0, 32'h500, 32'hB00B, 32'h0);
    #1;
    chk("t6FirstAddr", memAddr, 32'h400);
    chk("t6RdData", rdData, 32'h600D600D);
    step(0, 1, 0, 0, 32'h500, 32'hB00B, 32'h0);
    #1;
    chk("t6SecondWe", {31'b0, we}, 32'd1);
    chk("t6SecondAddr", memAddr, 32'h500);
    step(0, 1, 1, 0, 32'h500, 32'hB00B, 32'h0);
    step(0, 1, 0, 0, 32'h500, 32'hB00B, 32'h0);
    chk("t6Pulses", pulses, 32'd2);
    chk("t6ReqCycles", reqCnt, 32'd2);
    chk("t6StallCycles", stallCnt, 32'd4);

    // Random traffic with varying memory responsiveness.
    ackMode = 0;
    for (int i = 0; i < 3000; i++) begin
      int sel;
      bit r, w, a, c;
      if (i % 60 == 0) ackMode = int'($urandom_range(0, 2));
      sel = int'($urandom_range(0, 9));
      r = (sel <= 2) || (sel == 5);
      w = (sel == 3) || (sel == 4) || (sel == 5);
      if (sel == 5 && $urandom_range(0, 3) != 0) begin r = 1; w = 0; end
      case (ackMode)
        0: a = ($urandom_range(0, 1) == 1);
        1: a = 1'b0;
        default: a = ($urandom_range(0, 19) == 0);
      endcase
      c = ($urandom_range(0, 15) == 0);
      step(r, w, a, c, $urandom, $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
